alu_issue_stage: RTL and testbench

- Upstream issue/operand stage of the 16-bit processor.
- Accepts one instruction per cycle, decodes it, and reads operands from an internal 8x16 register file.
- Presents registered operands and opcode to the combinational ALU.
- Captures the ALU result and zero flag back into the register file and a flag register, with result forwarding so back-to-back dependent instructions need no stall.

---
 rtl/alu_issue_stage_pkg.sv | 69 ++++++
 rtl/alu_regfile.sv | 66 ++++++
 rtl/alu_issue_stage.sv | 170 +++++++++++++++++
 tb/tb_alu_issue_stage.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_issue_stage_pkg.sv
// -----------------------------------------------------------------------------
// alu_issue_stage_pkg
//
// Shared definitions for the issue stage of the 16-bit processor:
//   - ALU opcode encoding (must match the downstream combinational ALU)
//   - instruction field bit positions
//   - register address width
//   - decoded-instruction record and the decode helper that fills it
//
// Instruction word layout:
//   [15:13] op   [12:10] rd   [9:7] rs1   [6] i
//   i = 0 : [5:3] rs2, [2:0] ignored
//   i = 1 : [5:0] imm6, zero-extended to form operand B
// -----------------------------------------------------------------------------
package alu_issue_stage_pkg;

   // Eight architectural registers; r0 is hardwired to zero.
   localparam int REG_AW = $clog2(8);

   // Width of the instruction word and of its sub-fields.
   localparam int INSTR_W = 16;
   localparam int OP_W    = 3;
   localparam int IMM_W   = 6;

   // Field least-significant bit positions within the instruction word.
   localparam int OP_LSB      = 13;
   localparam int RD_LSB      = 10;
   localparam int RS1_LSB     = 7;
   localparam int IMM_SEL_BIT = 6;
   localparam int RS2_LSB     = 3;
   localparam int IMM6_LSB    = 0;

   // ALU opcode encoding shared with the execute unit.
   typedef enum logic [OP_W-1:0] {
      OP_ADD = 3'b000,
      OP_SUB = 3'b001,
      OP_AND = 3'b010,
      OP_OR  = 3'b011,
      OP_XOR = 3'b100,
      OP_SLT = 3'b101,
      OP_SHL = 3'b110,
      OP_SHR = 3'b111
   } alu_op_e;

   // Instruction after field extraction. rs2 and imm6 overlap in the
   // encoding; imm_sel decides which one is meaningful.
   typedef struct packed {
      alu_op_e           op;
      logic [REG_AW-1:0] rd;
      logic [REG_AW-1:0] rs1;
      logic [REG_AW-1:0] rs2;
      logic              imm_sel;
      logic [IMM_W-1:0]  imm6;
   } decoded_t;

   // Pure field extraction; no validity checks are needed because every
   // opcode value is defined.
   function automatic decoded_t decode_instr(input logic [INSTR_W-1:0] word);
      decoded_t d;
      d.op      = alu_op_e'(word[OP_LSB +: OP_W]);
      d.rd      = word[RD_LSB +: REG_AW];
      d.rs1     = word[RS1_LSB +: REG_AW];
      d.rs2     = word[RS2_LSB +: REG_AW];
      d.imm_sel = word[IMM_SEL_BIT];
      d.imm6    = word[IMM6_LSB +: IMM_W];
      return d;
   endfunction

endpackage

// File: rtl/alu_regfile.sv
// -----------------------------------------------------------------------------
// alu_regfile
//
// REG_COUNT x DW architectural register file for the issue stage.
//   - two combinational read ports (operand A / operand B)
//   - one combinational debug read port
//   - one synchronous write port; writes to r0 are suppressed
//   - r0 always reads as zero on every port
//   - asynchronous active-low reset clears every register
//
// A write on a rising edge becomes visible on the read ports only after that
// edge; reads in the same cycle as the write return the old contents.
//
// Ports:
//   clk       in   rising-edge clock
//   rst_n     in   asynchronous active-low reset
//   ra_addr   in   read port A address
//   ra_data   out  read port A data
//   rb_addr   in   read port B address
//   rb_data   out  read port B data
//   dbg_addr  in   debug read address
//   dbg_data  out  debug read data
//   we        in   write enable
//   waddr     in   write address
//   wdata     in   write data
// -----------------------------------------------------------------------------
module alu_regfile #(
   parameter int REG_COUNT = 8,
   parameter int DW        = 16
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [$clog2(REG_COUNT)-1:0] ra_addr,
   output logic [DW-1:0]                ra_data,
   input  logic [$clog2(REG_COUNT)-1:0] rb_addr,
   output logic [DW-1:0]                rb_data,
   input  logic [$clog2(REG_COUNT)-1:0] dbg_addr,
   output logic [DW-1:0]                dbg_data,
   input  logic                         we,
   input  logic [$clog2(REG_COUNT)-1:0] waddr,
   input  logic [DW-1:0]                wdata
);

   localparam int AW = $clog2(REG_COUNT);

   logic [DW-1:0] regs [REG_COUNT];

   // NOTE: the array is small and architecturally required to read zero after
   // reset, so it is built from resettable flops rather than a RAM macro.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < REG_COUNT; i++) begin
            regs[i] <= '0;
         end
      end else if (we && (waddr != AW'(0))) begin
         regs[waddr] <= wdata;
      end
   end

   // r0 is masked on the read side as well, so it reads zero regardless of
   // what the storage slot holds.
   assign ra_data  = (ra_addr  == AW'(0)) ? '0 : regs[ra_addr];
   assign rb_data  = (rb_addr  == AW'(0)) ? '0 : regs[rb_addr];
   assign dbg_data = (dbg_addr == AW'(0)) ? '0 : regs[dbg_addr];

endmodule

// File: rtl/alu_issue_stage.sv
// -----------------------------------------------------------------------------
// alu_issue_stage
//
// Issue/operand stage of the 16-bit processor. Each cycle it may accept one
// instruction, decode it, read its operands from the register file (or take
// them from the ALU result when the previous instruction writes the same
// register), and load them into the EX register that feeds the combinational
// ALU. The ALU result and zero flag come back the following edge and are
// written into the register file and the zero flag register.
//
// Timing: accepted at edge N -> operands at the ALU after N -> result written
// at edge N+1. Back-to-back dependent instructions never stall thanks to the
// forwarding path from alu_result.
//
// Ports:
//   clk          in   rising-edge clock
//   rst_n        in   asynchronous active-low reset
//   instr        in   instruction word
//   instr_valid  in   instr is valid this cycle
//   instr_ready  out  stage accepts instr this cycle (= ~hold)
//   hold         in   freezes EX register, register file and zero flag
//   alu_a        out  registered operand A
//   alu_b        out  registered operand B
//   alu_op       out  registered ALU opcode
//   alu_valid    out  EX register holds a valid instruction
//   alu_result   in   combinational ALU result
//   alu_zero     in   combinational ALU zero flag
//   zero_flag    out  zero flag of the last retired instruction
//   dbg_addr     in   debug register read address
//   dbg_data     out  debug register read data (r0 reads 0)
// -----------------------------------------------------------------------------
module alu_issue_stage
   import alu_issue_stage_pkg::*;
#(
   parameter int REG_COUNT = 8,
   parameter int DW        = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [15:0]       instr,
   input  logic              instr_valid,
   output logic              instr_ready,
   input  logic              hold,
   output logic [DW-1:0]     alu_a,
   output logic [DW-1:0]     alu_b,
   output logic [2:0]        alu_op,
   output logic              alu_valid,
   input  logic [DW-1:0]     alu_result,
   input  logic              alu_zero,
   output logic              zero_flag,
   input  logic [REG_AW-1:0] dbg_addr,
   output logic [DW-1:0]     dbg_data
);

   decoded_t          dec;
   logic [DW-1:0]     rs1_data;
   logic [DW-1:0]     rs2_data;
   logic [DW-1:0]     op_a;
   logic [DW-1:0]     op_b;
   logic              fwd_a;
   logic              fwd_b;
   logic [REG_AW-1:0] ex_rd;
   logic              ex_live;
   logic              wb_en;

   // ---------------------------------------------------------------------------
   // Decode
   // ---------------------------------------------------------------------------
   assign dec = decode_instr(instr);

   // The only stall source is the external hold.
   assign instr_ready = ~hold;

   // The EX instruction retires on any edge where it is valid and not held.
   // It only produces a register write when its destination is not r0.
   assign ex_live = alu_valid & ~hold;
   assign wb_en   = ex_live & (ex_rd != '0);

   // ---------------------------------------------------------------------------
   // Register file
   // ---------------------------------------------------------------------------
   alu_regfile #(
      .REG_COUNT (REG_COUNT),
      .DW        (DW)
   ) u_regfile (
      .clk      (clk),
      .rst_n    (rst_n),
      .ra_addr  (dec.rs1),
      .ra_data  (rs1_data),
      .rb_addr  (dec.rs2),
      .rb_data  (rs2_data),
      .dbg_addr (dbg_addr),
      .dbg_data (dbg_data),
      .we       (wb_en),
      .waddr    (ex_rd),
      .wdata    (alu_result)
   );

   // ---------------------------------------------------------------------------
   // Operand selection with forwarding
   //
   // The instruction in EX has not reached the register file yet, so a source
   // that names its destination must take alu_result directly. r0 is never a
   // forward source: an EX instruction targeting r0 writes nothing.
   // ---------------------------------------------------------------------------
   // NOTE: every signal is given a value before any condition so no path
   // through the block leaves a signal unassigned (which would infer a latch).
   always_comb begin
      fwd_a = 1'b0;
      fwd_b = 1'b0;
      op_a  = rs1_data;
      op_b  = rs2_data;

      if (alu_valid && (ex_rd != '0)) begin
         fwd_a = (dec.rs1 == ex_rd);
         fwd_b = !dec.imm_sel && (dec.rs2 == ex_rd);
      end

      if (fwd_a) begin
         op_a = alu_result;
      end

      if (dec.imm_sel) begin
         op_b = {{(DW-IMM_W){1'b0}}, dec.imm6};
      end else if (fwd_b) begin
         op_b = alu_result;
      end
   end

   // ---------------------------------------------------------------------------
   // EX register
   //
   // A bubble only clears alu_valid; the operand registers keep stale values
   // since nothing downstream looks at them without alu_valid.
   // ---------------------------------------------------------------------------
   // NOTE: state is updated with non-blocking assignments so every flop samples
   // pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         alu_a     <= '0;
         alu_b     <= '0;
         alu_op    <= 3'b000;
         alu_valid <= 1'b0;
         ex_rd     <= '0;
      end else if (!hold) begin
         alu_valid <= instr_valid;
         if (instr_valid) begin
            alu_a  <= op_a;
            alu_b  <= op_b;
            alu_op <= dec.op;
            ex_rd  <= dec.rd;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Zero flag
   //
   // Updated by every retiring instruction, including those targeting r0, so
   // an r0 destination can be used as a pure compare.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         zero_flag <= 1'b0;
      end else if (ex_live) begin
         zero_flag <= alu_zero;
      end
   end

endmodule

// File: tb/tb_alu_issue_stage.sv
// -----------------------------------------------------------------------------
// tb_alu_issue_stage
//
// Self-checking bench for alu_issue_stage. A behavioural ALU closes the loop
// from alu_a/alu_b/alu_op back to alu_result/alu_zero. The stimulus process
// issues directed instructions and pushes the hand-computed EX contents into a
// queue; a monitor process pops and compares whenever an instruction enters
// EX, checks that held EX contents stay frozen and that bubbles clear
// alu_valid. Register file and zero flag values are checked by the stimulus
// process through the debug port.
// -----------------------------------------------------------------------------
module tb_alu_issue_stage;

   localparam logic [2:0] ADD = 3'd0;
   localparam logic [2:0] SUB = 3'd1;
   localparam logic [2:0] AND = 3'd2;
   localparam logic [2:0] OR  = 3'd3;
   localparam logic [2:0] XOR = 3'd4;
   localparam logic [2:0] SLT = 3'd5;
   localparam logic [2:0] SHL = 3'd6;
   localparam logic [2:0] SHR = 3'd7;

   typedef struct {
      logic [2:0]  op;
      logic [15:0] a;
      logic [15:0] b;
   } ex_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] instr;
   logic        instr_valid;
   logic        instr_ready;
   logic        hold;
   logic [15:0] alu_a;
   logic [15:0] alu_b;
   logic [2:0]  alu_op;
   logic        alu_valid;
   logic [15:0] alu_result;
   logic        alu_zero;
   logic        zero_flag;
   logic [2:0]  dbg_addr;
   logic [15:0] dbg_data;

   ex_t exp_q[$];
   int  n_checks = 0;
   int  n_errors = 0;

   always #10 clk = ~clk;

   alu_issue_stage dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .instr       (instr),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .hold        (hold),
      .alu_a       (alu_a),
      .alu_b       (alu_b),
      .alu_op      (alu_op),
      .alu_valid   (alu_valid),
      .alu_result  (alu_result),
      .alu_zero    (alu_zero),
      .zero_flag   (zero_flag),
      .dbg_addr    (dbg_addr),
      .dbg_data    (dbg_data)
   );

   // Behavioural ALU feeding results back to the stage.
   always_comb begin
      alu_result = 16'd0;
      case (alu_op)
         ADD:     alu_result = alu_a + alu_b;
         SUB:     alu_result = alu_a - alu_b;
         AND:     alu_result = alu_a & alu_b;
         OR:      alu_result = alu_a | alu_b;
         XOR:     alu_result = alu_a ^ alu_b;
         SLT:     alu_result = ($signed(alu_a) < $signed(alu_b)) ? 16'd1 : 16'd0;
         SHL:     alu_result = alu_a << alu_b[3:0];
         default: alu_result = alu_a >> alu_b[3:0];
      endcase
   end
   assign alu_zero = (alu_result == 16'd0);

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [15:0] rr(input logic [2:0] op, input logic [2:0] rd,
                                      input logic [2:0] rs1, input logic [2:0] rs2);
      return {op, rd, rs1, 1'b0, rs2, 3'b000};
   endfunction

   function automatic logic [15:0] ri(input logic [2:0] op, input logic [2:0] rd,
                                      input logic [2:0] rs1, input logic [5:0] imm);
      return {op, rd, rs1, 1'b1, imm};
   endfunction

   // Present one instruction for one edge and record the EX contents it must
   // produce.
   task automatic issue(input logic [15:0] word, input logic [15:0] ea,
                        input logic [15:0] eb, input logic [2:0] eop);
      ex_t e;
      e.op = eop;
      e.a  = ea;
      e.b  = eb;
      exp_q.push_back(e);
      instr       = word;
      instr_valid = 1'b1;
      @(negedge clk);
   endtask

   task automatic idle();
      instr_valid = 1'b0;
      instr       = 16'h0000;
      @(negedge clk);
   endtask

   task automatic chk_reg(input logic [2:0] r, input logic [15:0] exp);
      dbg_addr = r;
      #1;
      check($sformatf("r%0d", r), dbg_data, exp);
   endtask

   // ---------------------------------------------------------------------------
   // Monitor: compares EX contents against the scoreboard queue.
   // ---------------------------------------------------------------------------
   initial begin
      ex_t  e;
      ex_t  last;
      logic last_valid;
      logic acc;
      logic hld;
      last.op    = 3'd0;
      last.a     = 16'd0;
      last.b     = 16'd0;
      last_valid = 1'b0;
      forever begin
         @(posedge clk);
         acc = rst_n && instr_valid && !hold;
         hld = rst_n && hold;
         @(negedge clk);
         if (acc) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_errors++;
               $display("FAIL sb_underflow: instruction entered EX with no expectation at %0t", $time);
            end else begin
               e = exp_q.pop_front();
               check("ex_valid", {15'd0, alu_valid}, 16'd1);
               check("ex_a", alu_a, e.a);
               check("ex_b", alu_b, e.b);
               check("ex_op", {13'd0, alu_op}, {13'd0, e.op});
               last       = e;
               last_valid = 1'b1;
            end
         end else if (hld) begin
            check("hold_valid", {15'd0, alu_valid}, {15'd0, last_valid});
            check("hold_a", alu_a, last.a);
            check("hold_b", alu_b, last.b);
            check("hold_op", {13'd0, alu_op}, {13'd0, last.op});
         end else begin
            check("bubble_valid", {15'd0, alu_valid}, 16'd0);
            last_valid = 1'b0;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Stimulus
   // ---------------------------------------------------------------------------
   initial begin
      rst_n       = 1'b0;
      hold        = 1'b0;
      instr_valid = 1'b0;
      instr       = 16'h0000;
      dbg_addr    = 3'd0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // Reset state
      check("rst_valid", {15'd0, alu_valid}, 16'd0);
      check("rst_zf", {15'd0, zero_flag}, 16'd0);
      check("rst_ready", {15'd0, instr_ready}, 16'd1);
      check("rst_a", alu_a, 16'd0);
      check("rst_b", alu_b, 16'd0);
      for (int r = 1; r < 8; r++) chk_reg(3'(r), 16'd0);

      // Immediate then dependent: both operands of the second forward
      issue(ri(ADD, 3'd1, 3'd0, 6'd5), 16'd0, 16'd5, ADD);
      issue(rr(ADD, 3'd2, 3'd1, 3'd1), 16'd5, 16'd5, ADD);
      idle();
      chk_reg(3'd1, 16'd5);
      chk_reg(3'd2, 16'd10);
      check("zf_add", {15'd0, zero_flag}, 16'd0);

      // Subtract to zero, then OR clears the flag
      issue(rr(SUB, 3'd3, 3'd1, 3'd1), 16'd5, 16'd5, SUB);
      issue(ri(OR, 3'd4, 3'd1, 6'd2), 16'd5, 16'd2, OR);
      check("zf_sub", {15'd0, zero_flag}, 16'd1);
      chk_reg(3'd3, 16'd0);
      idle();
      chk_reg(3'd4, 16'd7);
      check("zf_or", {15'd0, zero_flag}, 16'd0);

      // r0 target: no write, no forward, but the zero flag still updates
      issue(rr(SUB, 3'd3, 3'd1, 3'd1), 16'd5, 16'd5, SUB);
      issue(ri(ADD, 3'd0, 3'd0, 6'd9), 16'd0, 16'd9, ADD);
      check("zf_pre_r0", {15'd0, zero_flag}, 16'd1);
      issue(ri(ADD, 3'd5, 3'd0, 6'd1), 16'd0, 16'd1, ADD);
      check("zf_r0_target", {15'd0, zero_flag}, 16'd0);
      chk_reg(3'd0, 16'd0);
      idle();
      chk_reg(3'd5, 16'd1);
      chk_reg(3'd0, 16'd0);

      // Hold: EX instruction waits, held-off instructions are ignored
      issue(ri(ADD, 3'd6, 3'd0, 6'd3), 16'd0, 16'd3, ADD);
      hold = 1'b1;
      for (int k = 0; k < 4; k++) begin
         instr       = ri(ADD, 3'd7, 3'd0, 6'(20 + k));
         instr_valid = 1'b1;
         #1;
         check("ready_hold", {15'd0, instr_ready}, 16'd0);
         @(negedge clk);
         chk_reg(3'd6, 16'd0);
      end
      hold        = 1'b0;
      instr_valid = 1'b0;
      instr       = 16'h0000;
      #1;
      check("ready_release", {15'd0, instr_ready}, 16'd1);
      @(negedge clk);
      chk_reg(3'd6, 16'd3);
      chk_reg(3'd7, 16'd0);
      idle();
      chk_reg(3'd6, 16'd3);

      // Shift, bubble, set-less-than
      issue(ri(SHL, 3'd7, 3'd1, 6'd1), 16'd5, 16'd1, SHL);
      idle();
      chk_reg(3'd7, 16'd10);
      idle();
      chk_reg(3'd1, 16'd5);
      chk_reg(3'd2, 16'd10);
      chk_reg(3'd3, 16'd0);
      chk_reg(3'd4, 16'd7);
      chk_reg(3'd5, 16'd1);
      chk_reg(3'd6, 16'd3);
      chk_reg(3'd7, 16'd10);
      issue(rr(SLT, 3'd2, 3'd0, 3'd1), 16'd0, 16'd5, SLT);
      idle();
      chk_reg(3'd2, 16'd1);
      check("zf_slt", {15'd0, zero_flag}, 16'd0);

      // Reset mid-stream with a valid instruction in EX
      issue(rr(SUB, 3'd4, 3'd1, 3'd1), 16'd5, 16'd5, SUB);
      issue(ri(OR, 3'd3, 3'd0, 6'd7), 16'd0, 16'd7, OR);
      instr_valid = 1'b0;
      instr       = 16'h0000;
      check("pre_rst_valid", {15'd0, alu_valid}, 16'd1);
      check("pre_rst_zf", {15'd0, zero_flag}, 16'd1);
      #3;
      rst_n = 1'b0;
      #1;
      check("async_rst_valid", {15'd0, alu_valid}, 16'd0);
      check("async_rst_zf", {15'd0, zero_flag}, 16'd0);
      check("async_rst_op", {13'd0, alu_op}, 16'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      check("post_rst_a", alu_a, 16'd0);
      check("post_rst_b", alu_b, 16'd0);
      for (int r = 1; r < 8; r++) chk_reg(3'(r), 16'd0);
      idle();
      idle();
      chk_reg(3'd3, 16'd0);
      chk_reg(3'd4, 16'd0);
      check("post_rst_zf", {15'd0, zero_flag}, 16'd0);

      check("queue_empty", 16'(exp_q.size()), 16'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
